// File: rtl/ascon_pkg.sv
// ascon_pkg
//   Shared types and constants for the Ascon permutation datapath and its
//   round sequencer.
//   - word_t / state_t : 64-bit lane and 5-lane (320-bit) state
//   - ROTn_A / ROTn_B  : linear-layer rotate-right amounts for lane n
//   - RC               : the 12 standard round constants; p12 uses all of
//                        them, p8 starts at index 4, p6 starts at index 6
//   - rotr             : 64-bit rotate right
//   - round_const      : constant for step idx of a p^rounds permutation
package ascon_pkg;

  typedef logic [63:0]       word_t;
  typedef logic [4:0][63:0]  state_t;

  localparam int unsigned ROT0_A = 19;
  localparam int unsigned ROT0_B = 28;
  localparam int unsigned ROT1_A = 61;
  localparam int unsigned ROT1_B = 39;
  localparam int unsigned ROT2_A = 1;
  localparam int unsigned ROT2_B = 6;
  localparam int unsigned ROT3_A = 10;
  localparam int unsigned ROT3_B = 17;
  localparam int unsigned ROT4_A = 7;
  localparam int unsigned ROT4_B = 41;

  localparam int unsigned NUM_RC    = 12;
  localparam int unsigned P12_START = 0;
  localparam int unsigned P8_START  = 4;
  localparam int unsigned P6_START  = 6;

  localparam logic [7:0] RC [NUM_RC] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  // Rotate right; n = 0 is safe because a 64-bit shift by 64 yields zero.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // A p^rounds permutation uses the last `rounds` entries of RC, so step
  // idx maps to RC[NUM_RC - rounds + idx]. Out-of-range requests give 0.
  function automatic logic [7:0] round_const(input int unsigned rounds,
                                             input int unsigned idx);
    int unsigned pos;
    pos = NUM_RC - rounds + idx;
    if (rounds > NUM_RC || idx >= rounds) begin
      return 8'h00;
    end
    return RC[pos];
  endfunction

endpackage

// File: rtl/ascon_sbox_layer.sv
// ascon_sbox_layer
//   Purely combinational bitsliced Ascon 5-bit S-box applied to all 64
//   columns of the state at once. Column b is the 5-bit value
//   {x0[b], x1[b], x2[b], x3[b], x4[b]} with x0 as the MSB.
//   Ports:
//     x0..x4 : state lanes before the S-box (constant already added)
//     y0..y4 : state lanes after the S-box
module ascon_sbox_layer
  import ascon_pkg::*;
(
  input  logic [63:0] x0,
  input  logic [63:0] x1,
  input  logic [63:0] x2,
  input  logic [63:0] x3,
  input  logic [63:0] x4,
  output logic [63:0] y0,
  output logic [63:0] y1,
  output logic [63:0] y2,
  output logic [63:0] y3,
  output logic [63:0] y4
);

  // Input mixing; x1 and x3 pass through unchanged at this step.
  word_t a0, a2, a4;
  // Chi-like nonlinear terms, each built from the mixed lanes.
  word_t t0, t1, t2, t3, t4;
  // Lanes after the nonlinear XOR.
  word_t b0, b1, b2, b3, b4;

  assign a0 = x0 ^ x4;
  assign a4 = x4 ^ x3;
  assign a2 = x2 ^ x1;

  assign t0 = ~a0 & x1;
  assign t1 = ~x1 & a2;
  assign t2 = ~a2 & x3;
  assign t3 = ~x3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = x1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = x3 ^ t4;
  assign b4 = a4 ^ t0;

  // Output mixing: x1 and x3 take the updated b0/b2, x0 takes updated b4.
  assign y1 = b1 ^ b0;
  assign y0 = b0 ^ b4;
  assign y3 = b3 ^ b2;
  assign y2 = ~b2;
  assign y4 = b4;

endmodule

// File: rtl/ascon_round.sv
// ascon_round
//   One Ascon p_C round (constant addition, S-box layer, linear layer)
//   computed combinationally and captured in an output register, giving a
//   single pipeline stage with one round per cycle and no backpressure.
//   Ports:
//     clk, rst_n        : rising-edge clock, asynchronous active-low reset
//     in_valid          : qualifies c_r and x0..x4 this cycle
//     c_r               : round constant, XORed into the low byte of x2
//     x0..x4            : state lanes in (bit 63 is the lane MSB)
//     out_valid         : x*_out holds a round computed on the last edge
//     x0_out..x4_out    : registered state lanes after one round
//   The block keeps no round count; the caller sequences constants and may
//   feed x*_out back to x* to run p^n over n consecutive valid cycles.
module ascon_round
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  c_r,
  input  logic [63:0] x0,
  input  logic [63:0] x1,
  input  logic [63:0] x2,
  input  logic [63:0] x3,
  input  logic [63:0] x4,
  output logic        out_valid,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out
);

  // ---- stage p0: combinational round on the input lanes ----
  word_t x2_c_p0;
  word_t s0_p0, s1_p0, s2_p0, s3_p0, s4_p0;
  word_t l0_p0, l1_p0, l2_p0, l3_p0, l4_p0;
  logic  vld_p0;

  assign vld_p0  = in_valid;

  // Any 8-bit constant is accepted, not only the 12 standard ones.
  assign x2_c_p0 = x2 ^ {56'b0, c_r};

  ascon_sbox_layer u_sbox (
    .x0 (x0),
    .x1 (x1),
    .x2 (x2_c_p0),
    .x3 (x3),
    .x4 (x4),
    .y0 (s0_p0),
    .y1 (s1_p0),
    .y2 (s2_p0),
    .y3 (s3_p0),
    .y4 (s4_p0)
  );

  // Each lane diffuses only within itself.
  assign l0_p0 = s0_p0 ^ rotr(s0_p0, ROT0_A) ^ rotr(s0_p0, ROT0_B);
  assign l1_p0 = s1_p0 ^ rotr(s1_p0, ROT1_A) ^ rotr(s1_p0, ROT1_B);
  assign l2_p0 = s2_p0 ^ rotr(s2_p0, ROT2_A) ^ rotr(s2_p0, ROT2_B);
  assign l3_p0 = s3_p0 ^ rotr(s3_p0, ROT3_A) ^ rotr(s3_p0, ROT3_B);
  assign l4_p0 = s4_p0 ^ rotr(s4_p0, ROT4_A) ^ rotr(s4_p0, ROT4_B);

  // ---- stage p1: output register ----
  // The state is cleared by reset along with the valid flag so that a
  // mid-stream reset never leaks a previous state onto the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x0_out    <= '0;
      x1_out    <= '0;
      x2_out    <= '0;
      x3_out    <= '0;
      x4_out    <= '0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        x0_out <= l0_p0;
        x1_out <= l1_p0;
        x2_out <= l2_p0;
        x3_out <= l3_p0;
        x4_out <= l4_p0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_round.sv
module tb_ascon_round;

  typedef logic [4:0][63:0] st_t;

  // Ascon 5-bit S-box lookup table, index {x0,x1,x2,x3,x4} with x0 as MSB.
  localparam logic [4:0] SBOX_LUT [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [7:0] TB_RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  c_r = 8'h00;
  st_t         din = '0;
  logic        out_valid;
  logic [63:0] x0_out, x1_out, x2_out, x3_out, x4_out;
  st_t         dut_o;

  int errors = 0;
  int checks = 0;

  assign dut_o[0] = x0_out;
  assign dut_o[1] = x1_out;
  assign dut_o[2] = x2_out;
  assign dut_o[3] = x3_out;
  assign dut_o[4] = x4_out;

  always #5 clk = ~clk;

  ascon_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .c_r       (c_r),
    .x0        (din[0]),
    .x1        (din[1]),
    .x2        (din[2]),
    .x3        (din[3]),
    .x4        (din[4]),
    .out_valid (out_valid),
    .x0_out    (x0_out),
    .x1_out    (x1_out),
    .x2_out    (x2_out),
    .x3_out    (x3_out),
    .x4_out    (x4_out)
  );

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Reference round: table-driven S-box per bit column, then linear layer.
  function automatic st_t ref_round(input st_t s, input logic [7:0] c);
    st_t t;
    st_t o;
    logic [4:0] idx;
    logic [4:0] v;
    s[2] = s[2] ^ {56'b0, c};
    for (int b = 0; b < 64; b++) begin
      idx = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      v = SBOX_LUT[idx];
      t[0][b] = v[4];
      t[1][b] = v[3];
      t[2][b] = v[2];
      t[3][b] = v[1];
      t[4][b] = v[0];
    end
    o[0] = t[0] ^ ror64(t[0], 19) ^ ror64(t[0], 28);
    o[1] = t[1] ^ ror64(t[1], 61) ^ ror64(t[1], 39);
    o[2] = t[2] ^ ror64(t[2], 1)  ^ ror64(t[2], 6);
    o[3] = t[3] ^ ror64(t[3], 10) ^ ror64(t[3], 17);
    o[4] = t[4] ^ ror64(t[4], 7)  ^ ror64(t[4], 41);
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      c_r = 8'($urandom);
      for (int i = 0; i < 5; i++) din[i] = {$urandom, $urandom};
      step();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_o[i] !== 64'h0) begin
        errors++;
        $display("FAIL reset_x%0d_out got=%h want=%h", i, dut_o[i], 64'h0);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_zero_state();
    st_t exp;
    exp = '0;
    exp[2] = 64'hffffffffffffffff;
    in_valid = 1'b1;
    c_r = 8'h00;
    din = '0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_o[i] !== exp[i]) begin
        errors++;
        $display("FAIL zero_x%0d_out got=%h want=%h", i, dut_o[i], exp[i]);
      end
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_out_valid got=%b want=1", out_valid);
    end
  endtask

  task automatic test_known_vector();
    st_t v;
    st_t exp;
    v[0] = 64'h0123456789abcdef;
    v[1] = 64'h23456789abcdef01;
    v[2] = 64'h456789abcdef0123;
    v[3] = 64'h6789abcdef012345;
    v[4] = 64'h89abcde01234567f;
    exp = ref_round(v, 8'h1f);
    exp[0] = 64'h3c1748c9be2892ce;
    in_valid = 1'b1;
    c_r = 8'h1f;
    din = v;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_o[i] !== exp[i]) begin
        errors++;
        $display("FAIL known_x%0d_out got=%h want=%h", i, dut_o[i], exp[i]);
      end
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL known_out_valid got=%b want=1", out_valid);
    end
  endtask

  task automatic test_hold();
    st_t v;
    st_t exp;
    for (int i = 0; i < 5; i++) v[i] = 64'h0f1e2d3c4b5a6978 ^ {8'(i), 56'h0};
    exp = ref_round(v, 8'hf0);
    in_valid = 1'b1;
    c_r = 8'hf0;
    din = v;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_o[i] !== exp[i]) begin
        errors++;
        $display("FAIL hold_load_x%0d_out got=%h want=%h", i, dut_o[i], exp[i]);
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      c_r = 8'($urandom);
      for (int i = 0; i < 5; i++) din[i] = {$urandom, $urandom};
      step();
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dut_o[i] !== exp[i]) begin
          errors++;
          $display("FAIL hold_c%0d_x%0d_out got=%h want=%h", c, i, dut_o[i], exp[i]);
        end
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d_out_valid got=%b want=0", c, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    st_t v;
    st_t exp;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) v[i] = {$urandom, $urandom};
      exp = ref_round(v, TB_RC[k + 3]);
      in_valid = 1'b1;
      c_r = TB_RC[k + 3];
      din = v;
      step();
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dut_o[i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b_k%0d_x%0d_out got=%h want=%h", k, i, dut_o[i], exp[i]);
        end
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_k%0d_out_valid got=%b want=1", k, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    st_t v;
    for (int i = 0; i < 5; i++) v[i] = 64'hdeadbeefcafef00d + 64'(i);
    in_valid = 1'b1;
    c_r = 8'h4b;
    din = v;
    step();
    // Assert reset between edges and look before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_o[i] !== 64'h0) begin
        errors++;
        $display("FAIL async_rst_x%0d_out got=%h want=%h", i, dut_o[i], 64'h0);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_out_valid got=%b want=0", out_valid);
    end
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || x0_out !== 64'h0) begin
      errors++;
      $display("FAIL post_rst_idle got=%b/%h want=0/0", out_valid, x0_out);
    end
    in_valid = 1'b1;
    c_r = 8'h00;
    din = '0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || x2_out !== 64'hffffffffffffffff) begin
      errors++;
      $display("FAIL post_rst_capture got=%b/%h want=1/ffffffffffffffff", out_valid, x2_out);
    end
  endtask

  task automatic test_p12_loop();
    st_t iv;
    st_t exp;
    iv = '0;
    iv[0] = 64'h80400c0600000000;
    exp = iv;
    for (int r = 0; r < 12; r++) exp = ref_round(exp, TB_RC[r]);
    in_valid = 1'b1;
    c_r = TB_RC[0];
    din = iv;
    for (int r = 0; r < 12; r++) begin
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL p12_r%0d_out_valid got=%b want=1", r, out_valid);
      end
      din = dut_o;
      if (r < 11) c_r = TB_RC[r + 1];
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_o[i] !== exp[i]) begin
        errors++;
        $display("FAIL p12_x%0d_out got=%h want=%h", i, dut_o[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_known_vector();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_p12_loop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
